// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, write ports, issue/flush control
// and the registered busy count. clk/rstn stay outside as plain ports.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 64,
  parameter int NRD  = 3,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NWR-1:0]      we;
  logic [NWR-1:0]      wclr;
  logic                stall;
  logic                iss_valid;
  logic [AW-1:0]       iss_a;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output ra, wa, wd, we, wclr, stall, iss_valid, iss_a, flush,
    input  rd, rbusy, busy_cnt
  );

  modport slave (
    input  ra, wa, wd, we, wclr, stall, iss_valid, iss_a, flush,
    output rd, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, hardwired r0 and a
// per-register busy scoreboard (issue sets, writeback clears, flush wipes).

module regfile_sb_rdport #(
  parameter int XLEN = 32,
  parameter int NREG = 64,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]              ra,
  input  logic [NREG-1:0][XLEN-1:0]  rf,
  input  logic [NREG-1:0]            busy,
  input  logic [NWR-1:0]             commit,
  input  logic [NWR-1:0]             wclr,
  input  logic [NWR-1:0][AW-1:0]     wa,
  input  logic [NWR-1:0][XLEN-1:0]   wd,
  output logic [XLEN-1:0]            rd,
  output logic                       rbusy
);
  // commit already carries ~stall, so a stalled cycle reads stored state only.
  // Ascending loop lets the highest-indexed matching port win.
  always_comb begin
    rd    = rf[ra];
    rbusy = busy[ra];
    for (int j = 0; j < NWR; j++) begin
      if (commit[j] && (wa[j] == ra)) begin
        rd = wd[j];
        if (wclr[j]) rbusy = 1'b0;
      end
    end
    if (ra == '0) begin
      rd    = '0;
      rbusy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 64,
  parameter int NRD  = 3,
  parameter int NWR  = 2
) (
  input logic          clk,
  input logic          rstn,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]    ra_a;
  logic [NRD-1:0][XLEN-1:0]  rd_a;
  logic [NRD-1:0]            rbusy_a;
  logic [NWR-1:0][AW-1:0]    wa_a;
  logic [NWR-1:0][XLEN-1:0]  wd_a;
  logic [NWR-1:0]            commit;

  logic [NREG-1:0][XLEN-1:0] rf_q, rf_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               busy_cnt_q, busy_cnt_d;

  assign ra_a         = bus.ra;
  assign wa_a         = bus.wa;
  assign wd_a         = bus.wd;
  assign bus.rd       = rd_a;
  assign bus.rbusy    = rbusy_a;
  assign bus.busy_cnt = busy_cnt_q;

  always_comb begin
    commit = '0;
    for (int j = 0; j < NWR; j++)
      commit[j] = bus.we[j] & ~bus.stall & (wa_a[j] != '0);
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NWR  (NWR),
      .AW   (AW)
    ) u_rd (
      .ra     (ra_a[k]),
      .rf     (rf_q),
      .busy   (busy_q),
      .commit (commit),
      .wclr   (bus.wclr),
      .wa     (wa_a),
      .wd     (wd_a),
      .rd     (rd_a[k]),
      .rbusy  (rbusy_a[k])
    );
  end

  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NWR; j++)
      if (commit[j]) rf_d[wa_a[j]] = wd_a[j];
    rf_d[0] = '0;
  end

  // Clear before set so a same-cycle issue re-marks a register its old
  // producer is retiring; flush overrides both and ignores stall.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++)
      if (commit[j] && bus.wclr[j]) busy_d[wa_a[j]] = 1'b0;
    if (bus.iss_valid && !bus.stall && (bus.iss_a != '0))
      busy_d[bus.iss_a] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++)
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rf_q       <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based
// model of the register file and scoreboard.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 64;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [XLEN-1:0] mrf   [NREG];
  bit              mbusy [NREG];

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] get_ra(int k);   return bus.ra[k*AW +: AW];     endfunction
  function automatic logic [AW-1:0] get_wa(int j);   return bus.wa[j*AW +: AW];     endfunction
  function automatic logic [XLEN-1:0] get_wd(int j); return bus.wd[j*XLEN +: XLEN]; endfunction

  function automatic bit writes(int j);
    return bus.we[j] && !bus.stall && get_wa(j) != 0;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int k);
    logic [XLEN-1:0] v;
    logic [AW-1:0]   a = get_ra(k);
    if (a == 0) return '0;
    v = mrf[a];
    for (int j = 0; j < NWR; j++) if (writes(j) && get_wa(j) == a) v = get_wd(j);
    return v;
  endfunction

  function automatic bit exp_rbusy(int k);
    logic [AW-1:0] a = get_ra(k);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NWR; j++) if (writes(j) && bus.wclr[j] && get_wa(j) == a) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(mbusy[r]);
    return n;
  endfunction

  // Clock-edge behaviour of the whole block, applied to the model.
  task automatic model_edge();
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) begin mrf[r] = '0; mbusy[r] = 1'b0; end
      return;
    end
    for (int j = 0; j < NWR; j++) if (writes(j)) mrf[get_wa(j)] = get_wd(j);
    if (bus.flush) begin
      for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
    end else begin
      for (int j = 0; j < NWR; j++) if (writes(j) && bus.wclr[j]) mbusy[get_wa(j)] = 1'b0;
      if (bus.iss_valid && !bus.stall && bus.iss_a != 0) mbusy[bus.iss_a] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rstn = 1'b1;
    bus.ra = '0; bus.wa = '0; bus.wd = '0; bus.we = '0; bus.wclr = '0;
    bus.stall = 1'b0; bus.iss_valid = 1'b0; bus.iss_a = '0; bus.flush = 1'b0;
  endtask

  task automatic set_ra(int k, int a); bus.ra[k*AW +: AW] = AW'(a); endtask
  task automatic set_w(int j, int a, logic [XLEN-1:0] d, bit clr);
    bus.we[j] = 1'b1; bus.wa[j*AW +: AW] = AW'(a); bus.wd[j*XLEN +: XLEN] = d; bus.wclr[j] = clr;
  endtask
  task automatic issue(int a); bus.iss_valid = 1'b1; bus.iss_a = AW'(a); endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic cyc(input string tag);
    #3;
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("%s rd%0d", tag, k), 64'(bus.rd[k*XLEN +: XLEN]), 64'(exp_rd(k)));
      chk($sformatf("%s rbusy%0d", tag, k), 64'(bus.rbusy[k]), 64'(exp_rbusy(k)));
    end
    chk($sformatf("%s busy_cnt", tag), 64'(bus.busy_cnt), 64'(exp_cnt()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    idle(); cyc("rst_r0");
    idle(); for (int k = 0; k < NRD; k++) set_ra(k, 5);  cyc("rst_r5");
    idle(); for (int k = 0; k < NRD; k++) set_ra(k, 63); cyc("rst_r63");

    idle(); set_w(0, 5, 32'hDEADBEEF, 0); set_ra(0, 5); cyc("byp_r5");
    idle(); set_ra(0, 5); cyc("store_r5");
    idle(); set_w(0, 0, 32'h1234, 0); set_ra(0, 0); cyc("wr_r0");
    idle(); set_ra(0, 0); cyc("rd_r0");

    idle(); set_w(0, 7, 32'h11, 0); set_w(1, 7, 32'h22, 0); set_ra(0, 7); cyc("coll_byp");
    idle(); set_ra(0, 7); cyc("coll_store");
    idle(); set_w(0, 7, 32'h33, 0); set_w(1, 7, 32'h44, 0); bus.stall = 1'b1; set_ra(0, 7); cyc("coll_stall");
    idle(); set_ra(0, 7); cyc("coll_after_stall");

    idle(); issue(9); set_ra(0, 9); cyc("iss9");
    idle(); set_ra(0, 9); cyc("busy9");
    idle(); set_w(0, 9, 32'h99, 1); set_ra(0, 9); cyc("clr9");
    idle(); set_ra(0, 9); cyc("clr9_after");

    idle(); issue(9); cyc("iss9b");
    idle(); issue(9); set_w(1, 9, 32'h98, 1); set_ra(1, 9); cyc("set_wins");
    idle(); set_ra(1, 9); cyc("set_wins_after");

    idle(); issue(3); cyc("iss3");
    idle(); issue(4); cyc("iss4");
    idle(); issue(5); set_ra(0, 3); set_ra(1, 4); cyc("iss5");
    idle(); issue(6); bus.flush = 1'b1; set_ra(0, 3); set_ra(1, 4); set_ra(2, 5); cyc("flush");
    idle(); set_ra(0, 3); set_ra(1, 4); set_ra(2, 5); cyc("post_flush");
    idle(); issue(10); set_w(0, 11, 32'hABCD, 0); cyc("pre_rst");
    idle(); rstn = 1'b0; issue(12); set_w(0, 13, 32'h5555, 0); set_ra(0, 10); set_ra(1, 11); cyc("mid_rst");
    idle(); set_ra(0, 10); set_ra(1, 11); set_ra(2, 5); cyc("after_rst");

    for (int i = 0; i < 400; i++) begin
      idle();
      for (int k = 0; k < NRD; k++)
        set_ra(k, ($urandom_range(0, 7) == 0) ? $urandom_range(0, NREG-1) : $urandom_range(0, 15));
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 1) == 1) set_w(j, $urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) issue($urandom_range(0, 15));
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      rstn      = ($urandom_range(0, 49) != 0);
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
